trashbin_mem_ctrl: RTL and testbench

Parametrised memory/IO bus controller between the Trashbin core bus and its slaves. It replaces the hard-wired ReadOK/WriteOK=1 coupling with a real handshake. It decodes each core access to a synchronous RAM region, a bank of memory-mapped IO registers (LED/hex display sources), or unmapped space. It generates ReadOK/WriteOK with the correct latency per region.

---
 rtl/trashbin_bus_pkg.sv | 13 +
 rtl/trashbin_addr_decode.sv | 31 +++
 rtl/trashbin_mem_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_trashbin_mem_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trashbin_bus_pkg.sv
// Shared types and constants for the Trashbin core bus controller and its address decoder.
package trashbin_bus_pkg;

   typedef enum logic [1:0] {IDLE, RAM_WAIT, RESPOND} state_t;
   typedef enum logic [1:0] {REG_RAM, REG_IO, REG_NONE} region_t;

   localparam logic [31:0] DEFAULT_IO_BASE  = 32'hFFFF_0000;
   localparam int          MAX_READ_LATENCY = 4;
   localparam int          CNT_W            = $clog2(MAX_READ_LATENCY + 1);
   // Wide enough for 16 IO registers plus the two error-latch words.
   localparam int          IO_IDX_W         = 5;

endpackage

// File: rtl/trashbin_addr_decode.sv
// Combinational decode of a core address into region (RAM / IO / unmapped) plus RAM word
// index and IO register index. RAM takes priority; IO hits need addr >= IO_BASE.
module trashbin_addr_decode
   import trashbin_bus_pkg::*;
#(
   parameter int                    ADDR_WIDTH     = 32,
   parameter int                    RAM_ADDR_WIDTH = 14,
   parameter logic [ADDR_WIDTH-1:0] IO_BASE        = ADDR_WIDTH'(DEFAULT_IO_BASE),
   parameter int                    NUM_IO_MAPPED  = 4
) (
   input  logic [ADDR_WIDTH-1:0]     addr,
   output region_t                   region,
   output logic [RAM_ADDR_WIDTH-1:0] ram_idx,
   output logic [IO_IDX_W-1:0]       io_idx
);

   logic [ADDR_WIDTH-1:0] io_word;

   always_comb begin
      io_word = (addr - IO_BASE) >> 2;
      ram_idx = addr[RAM_ADDR_WIDTH+1:2];
      io_idx  = io_word[IO_IDX_W-1:0];
      if (addr[ADDR_WIDTH-1:RAM_ADDR_WIDTH+2] == '0)
         region = REG_RAM;
      else if ((addr >= IO_BASE) && (io_word < ADDR_WIDTH'(NUM_IO_MAPPED)))
         region = REG_IO;
      else
         region = REG_NONE;
   end

endmodule

// File: rtl/trashbin_mem_ctrl.sv
// Trashbin core bus controller: RAM / IO-register / unmapped decode with ReadOK/WriteOK/BusError
// handshake. Define TRASHBIN_BUSERR_LATCH_EN to add the sticky ErrorAddress/ErrorValid latch.
module trashbin_mem_ctrl
   import trashbin_bus_pkg::*;
#(
   parameter int                    DATA_WIDTH       = 32,
   parameter int                    ADDR_WIDTH       = 32,
   parameter int                    RAM_ADDR_WIDTH   = 14,
   parameter int                    RAM_READ_LATENCY = 1,
   parameter logic [ADDR_WIDTH-1:0] IO_BASE          = ADDR_WIDTH'(DEFAULT_IO_BASE),
   parameter int                    NUM_IO_REGS      = 4
) (
   input  logic                              CoreClock,
   input  logic                              Reset,
   input  logic [ADDR_WIDTH-1:0]             CoreAddress,
   input  logic                              CoreReadAssert,
   input  logic                              CoreWriteAssert,
   input  logic [DATA_WIDTH-1:0]             CoreWriteData,
   output logic [DATA_WIDTH-1:0]             CoreReadData,
   output logic                              CoreReadOK,
   output logic                              CoreWriteOK,
   output logic                              BusError,
   output logic [RAM_ADDR_WIDTH-1:0]         RamAddress,
   output logic [DATA_WIDTH-1:0]             RamWriteData,
   output logic                              RamWriteEnable,
   input  logic [DATA_WIDTH-1:0]             RamReadData,
   output logic [NUM_IO_REGS*DATA_WIDTH-1:0] IoRegs
);

`ifdef TRASHBIN_BUSERR_LATCH_EN
   localparam int NUM_IO_MAPPED = NUM_IO_REGS + 2;
`else
   localparam int NUM_IO_MAPPED = NUM_IO_REGS;
`endif

   state_t                                 state, state_nxt;
   logic [CNT_W-1:0]                       cnt, cnt_nxt;
   logic [RAM_ADDR_WIDTH-1:0]              ram_addr, ram_addr_nxt;
   logic [DATA_WIDTH-1:0]                  wr_data, wr_data_nxt;
   logic [DATA_WIDTH-1:0]                  rd_data, rd_data_nxt;
   logic                                   rd_ok, rd_ok_nxt, wr_ok, wr_ok_nxt;
   logic                                   bus_err, bus_err_nxt, ram_we, ram_we_nxt;
   logic [NUM_IO_REGS-1:0][DATA_WIDTH-1:0] io_regs, io_regs_nxt;
   logic [DATA_WIDTH-1:0]                  io_rd;

   region_t                   region;
   logic [RAM_ADDR_WIDTH-1:0] ram_idx;
   logic [IO_IDX_W-1:0]       io_idx;

   trashbin_addr_decode #(
      .ADDR_WIDTH    (ADDR_WIDTH),
      .RAM_ADDR_WIDTH(RAM_ADDR_WIDTH),
      .IO_BASE       (IO_BASE),
      .NUM_IO_MAPPED (NUM_IO_MAPPED)
   ) u_decode (
      .addr   (CoreAddress),
      .region (region),
      .ram_idx(ram_idx),
      .io_idx (io_idx)
   );

`ifdef TRASHBIN_BUSERR_LATCH_EN
   logic [ADDR_WIDTH-1:0] err_addr;
   logic                  err_vld;
   logic                  err_clr;

   assign err_clr = (state == IDLE) && CoreWriteAssert && (region == REG_IO)
                    && (io_idx == IO_IDX_W'(NUM_IO_REGS + 1));

   // Capture only the first error; a capture outranks a clear in the same cycle.
   always_ff @(posedge CoreClock or posedge Reset) begin
      if (Reset) begin
         err_addr <= '0;
         err_vld  <= 1'b0;
      end else if (bus_err_nxt && !err_vld) begin
         err_addr <= CoreAddress;
         err_vld  <= 1'b1;
      end else if (err_clr) begin
         err_addr <= '0;
         err_vld  <= 1'b0;
      end
   end
`endif

   always_comb begin
      io_rd = '0;
      for (int i = 0; i < NUM_IO_REGS; i++)
         if (io_idx == IO_IDX_W'(i)) io_rd = io_regs[i];
`ifdef TRASHBIN_BUSERR_LATCH_EN
      if (io_idx == IO_IDX_W'(NUM_IO_REGS))     io_rd = DATA_WIDTH'(err_addr);
      if (io_idx == IO_IDX_W'(NUM_IO_REGS + 1)) io_rd = DATA_WIDTH'(err_vld);
`endif
   end

   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      ram_addr_nxt = ram_addr;
      wr_data_nxt  = wr_data;
      rd_data_nxt  = '0;
      rd_ok_nxt    = 1'b0;
      wr_ok_nxt    = 1'b0;
      bus_err_nxt  = 1'b0;
      ram_we_nxt   = 1'b0;
      io_regs_nxt  = io_regs;
      case (state)
         IDLE: begin
            if (CoreReadAssert || CoreWriteAssert) begin
               ram_addr_nxt = ram_idx;
               wr_data_nxt  = CoreWriteData;
               if (CoreWriteAssert) begin
                  // A simultaneous read is dropped and flagged; the write still happens.
                  wr_ok_nxt   = 1'b1;
                  bus_err_nxt = CoreReadAssert || (region == REG_NONE);
                  state_nxt   = RESPOND;
                  if (region == REG_RAM)
                     ram_we_nxt = 1'b1;
                  else if (region == REG_IO)
                     for (int i = 0; i < NUM_IO_REGS; i++)
                        if (io_idx == IO_IDX_W'(i)) io_regs_nxt[i] = CoreWriteData;
               end else begin
                  case (region)
                     REG_RAM: begin
                        state_nxt = RAM_WAIT;
                        cnt_nxt   = CNT_W'(1);
                     end
                     REG_IO: begin
                        rd_ok_nxt   = 1'b1;
                        rd_data_nxt = io_rd;
                        state_nxt   = RESPOND;
                     end
                     default: begin
                        rd_ok_nxt   = 1'b1;
                        bus_err_nxt = 1'b1;
                        state_nxt   = RESPOND;
                     end
                  endcase
               end
            end
         end
         RAM_WAIT: begin
            if (cnt == CNT_W'(RAM_READ_LATENCY)) begin
               rd_data_nxt = RamReadData;
               rd_ok_nxt   = 1'b1;
               cnt_nxt     = '0;
               state_nxt   = RESPOND;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         RESPOND:  state_nxt = IDLE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CoreClock or posedge Reset) begin
      if (Reset) begin
         state    <= IDLE;
         cnt      <= '0;
         ram_addr <= '0;
         wr_data  <= '0;
         rd_data  <= '0;
         rd_ok    <= 1'b0;
         wr_ok    <= 1'b0;
         bus_err  <= 1'b0;
         ram_we   <= 1'b0;
         io_regs  <= '0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         ram_addr <= ram_addr_nxt;
         wr_data  <= wr_data_nxt;
         rd_data  <= rd_data_nxt;
         rd_ok    <= rd_ok_nxt;
         wr_ok    <= wr_ok_nxt;
         bus_err  <= bus_err_nxt;
         ram_we   <= ram_we_nxt;
         io_regs  <= io_regs_nxt;
      end
   end

   // The RAM sees the live address while idle so its read latency starts at acceptance.
   assign RamAddress     = (state == IDLE) ? ram_idx : ram_addr;
   assign RamWriteData   = wr_data;
   assign RamWriteEnable = ram_we;
   assign CoreReadData   = rd_data;
   assign CoreReadOK     = rd_ok;
   assign CoreWriteOK    = wr_ok;
   assign BusError       = bus_err;
   assign IoRegs         = io_regs;

endmodule

// File: tb/tb_trashbin_mem_ctrl.sv
// Directed bench for trashbin_mem_ctrl with a 3-cycle RAM model and hand-computed expectations.
module tb_trashbin_mem_ctrl;

   localparam int          LAT = 3;
   localparam logic [31:0] IOB = 32'hFFFF_0000;

   logic         CoreClock;
   logic         Reset;
   logic [31:0]  CoreAddress;
   logic         CoreReadAssert;
   logic         CoreWriteAssert;
   logic [31:0]  CoreWriteData;
   logic [31:0]  CoreReadData;
   logic         CoreReadOK;
   logic         CoreWriteOK;
   logic         BusError;
   logic [13:0]  RamAddress;
   logic [31:0]  RamWriteData;
   logic         RamWriteEnable;
   logic [31:0]  RamReadData;
   logic [127:0] IoRegs;

   int checks   = 0;
   int failures = 0;

   int          lat, ok1, ok2, okcnt;
   logic [31:0] rdat, rdat2;
   logic        rok, wok, berr, we;
   logic [13:0] ra;

   trashbin_mem_ctrl #(
      .DATA_WIDTH      (32),
      .ADDR_WIDTH      (32),
      .RAM_ADDR_WIDTH  (14),
      .RAM_READ_LATENCY(LAT),
      .IO_BASE         (IOB),
      .NUM_IO_REGS     (4)
   ) dut (
      .CoreClock      (CoreClock),
      .Reset          (Reset),
      .CoreAddress    (CoreAddress),
      .CoreReadAssert (CoreReadAssert),
      .CoreWriteAssert(CoreWriteAssert),
      .CoreWriteData  (CoreWriteData),
      .CoreReadData   (CoreReadData),
      .CoreReadOK     (CoreReadOK),
      .CoreWriteOK    (CoreWriteOK),
      .BusError       (BusError),
      .RamAddress     (RamAddress),
      .RamWriteData   (RamWriteData),
      .RamWriteEnable (RamWriteEnable),
      .RamReadData    (RamReadData),
      .IoRegs         (IoRegs)
   );

   initial CoreClock = 1'b0;
   always #5 CoreClock = ~CoreClock;

   // Synchronous RAM: address sampled on an edge, data valid LAT-1 edges later.
   logic [31:0] mem  [0:16383];
   logic [31:0] pipe [LAT];
   always @(posedge CoreClock) begin
      if (RamWriteEnable) mem[RamAddress] <= RamWriteData;
      pipe[0] <= mem[RamAddress];
      for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
   end
   assign RamReadData = pipe[LAT-1];

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk128(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns cycles from acceptance to the OK pulse (0 = timed out).
   task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdat);
      CoreAddress     = addr;
      CoreWriteData   = wdat;
      CoreReadAssert  = rd;
      CoreWriteAssert = wr;
      lat = 0; rdat = '0; rok = 1'b0; wok = 1'b0; berr = 1'b0; we = 1'b0; ra = '0;
      for (int n = 1; n <= 20; n++) begin
         @(negedge CoreClock);
         if (CoreReadOK || CoreWriteOK) begin
            lat  = n;
            rdat = CoreReadData;
            rok  = CoreReadOK;
            wok  = CoreWriteOK;
            berr = BusError;
            we   = RamWriteEnable;
            ra   = RamAddress;
            break;
         end
      end
      CoreReadAssert  = 1'b0;
      CoreWriteAssert = 1'b0;
   endtask

   task automatic idle_check(input string tag);
      @(negedge CoreClock);
      chk1({tag, "_no_ok"}, CoreReadOK | CoreWriteOK, 1'b0);
      chk1({tag, "_we_low"}, RamWriteEnable, 1'b0);
   endtask

   initial begin
      Reset = 1'b1; CoreAddress = '0; CoreReadAssert = 1'b0; CoreWriteAssert = 1'b0;
      CoreWriteData = '0;
      repeat (3) @(negedge CoreClock);
      chk1("rst_rok", CoreReadOK, 1'b0);
      chk1("rst_wok", CoreWriteOK, 1'b0);
      chk1("rst_berr", BusError, 1'b0);
      chk1("rst_we", RamWriteEnable, 1'b0);
      chk32("rst_rdata", CoreReadData, 32'h0);
      chk128("rst_ioregs", IoRegs, 128'h0);
      Reset = 1'b0;
      @(negedge CoreClock);

      // RAM write then read back
      access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
      chk32("ramwr_lat", lat, 1);
      chk1("ramwr_we", we, 1'b1);
      chk32("ramwr_addr", {18'h0, ra}, 32'h4);
      chk32("ramwr_wdata", RamWriteData, 32'hDEADBEEF);
      chk1("ramwr_berr", berr, 1'b0);
      idle_check("ramwr");
      access(1'b1, 1'b0, 32'h10, 32'h0);
      chk32("ramrd_lat", lat, LAT + 1);
      chk32("ramrd_data", rdat, 32'hDEADBEEF);
      chk1("ramrd_berr", berr, 1'b0);
      idle_check("ramrd");

      // Back-to-back held read: OK at LAT+1, next one LAT+2 later
      access(1'b0, 1'b1, 32'h20, 32'h12345678);
      idle_check("wr20");
      CoreAddress = 32'h20; CoreReadAssert = 1'b1;
      ok1 = 0; ok2 = 0; okcnt = 0; rdat2 = '0;
      for (int n = 1; n <= 12; n++) begin
         @(negedge CoreClock);
         if (CoreReadOK) begin
            okcnt++;
            if (ok1 == 0) ok1 = n;
            else if (ok2 == 0) begin
               ok2 = n; rdat2 = CoreReadData; CoreReadAssert = 1'b0;
            end
         end
      end
      chk32("b2b_first_ok", ok1, 4);
      chk32("b2b_second_ok", ok2, 9);
      chk32("b2b_ok_count", okcnt, 2);
      chk32("b2b_data", rdat2, 32'h12345678);

      // IO register write / read
      access(1'b0, 1'b1, IOB + 32'h4, 32'h3FF);
      chk32("iowr_lat", lat, 1);
      chk1("iowr_we", we, 1'b0);
      chk128("iowr_regs", IoRegs, 128'h0000_0000_0000_0000_0000_03FF_0000_0000);
      idle_check("iowr");
      access(1'b1, 1'b0, IOB + 32'h4, 32'h0);
      chk32("iord_lat", lat, 1);
      chk32("iord_data", rdat, 32'h3FF);
      idle_check("iord");
      access(1'b0, 1'b1, IOB, 32'hA5A5);
      idle_check("iowr0");
      access(1'b1, 1'b0, IOB + 32'hC, 32'h0);
      chk32("iord3_data", rdat, 32'h0);
      chk128("io_regs2", IoRegs, 128'h0000_0000_0000_0000_0000_03FF_0000_A5A5);
      idle_check("iord3");

      // Unmapped accesses
      access(1'b1, 1'b0, IOB + 32'h10, 32'h0);
      chk32("unm_io_lat", lat, 1);
      chk1("unm_io_rok", rok, 1'b1);
      chk1("unm_io_berr", berr, 1'b1);
      chk32("unm_io_data", rdat, 32'h0);
      idle_check("unm_io");
      access(1'b1, 1'b0, 32'h0001_0000, 32'h0);
      chk32("unm_hi_lat", lat, 1);
      chk1("unm_hi_berr", berr, 1'b1);
      chk32("unm_hi_data", rdat, 32'h0);
      idle_check("unm_hi");
      access(1'b0, 1'b1, IOB + 32'h10, 32'hFFFF_FFFF);
      chk1("unm_wr_wok", wok, 1'b1);
      chk1("unm_wr_berr", berr, 1'b1);
      chk1("unm_wr_we", we, 1'b0);
      chk128("unm_wr_regs", IoRegs, 128'h0000_0000_0000_0000_0000_03FF_0000_A5A5);
      idle_check("unm_wr");

      // Read and write together: write wins, error flagged
      access(1'b1, 1'b1, 32'h8, 32'hCAFEF00D);
      chk1("both_wok", wok, 1'b1);
      chk1("both_rok", rok, 1'b0);
      chk1("both_berr", berr, 1'b1);
      chk1("both_we", we, 1'b1);
      chk32("both_addr", {18'h0, ra}, 32'h2);
      idle_check("both");
      access(1'b1, 1'b0, 32'h8, 32'h0);
      chk32("both_readback", rdat, 32'hCAFEF00D);
      idle_check("both_rb");

      // Request dropped right after acceptance still completes
      CoreAddress = 32'h10; CoreReadAssert = 1'b1;
      @(negedge CoreClock);
      CoreReadAssert = 1'b0;
      lat = 0; rdat = '0;
      for (int n = 2; n <= 12; n++) begin
         @(negedge CoreClock);
         if (CoreReadOK && lat == 0) begin lat = n; rdat = CoreReadData; end
      end
      chk32("drop_lat", lat, LAT + 1);
      chk32("drop_data", rdat, 32'hDEADBEEF);

      // Reset during a RAM write strobe aborts the write
      access(1'b0, 1'b1, 32'h40, 32'h11111111);
      idle_check("wr40");
      CoreAddress = 32'h40; CoreWriteData = 32'h22222222; CoreWriteAssert = 1'b1;
      @(negedge CoreClock);
      chk1("abort_we_before", RamWriteEnable, 1'b1);
      Reset = 1'b1;
      #1;
      chk1("abort_we_async", RamWriteEnable, 1'b0);
      chk1("abort_wok_async", CoreWriteOK, 1'b0);
      chk128("abort_ioregs", IoRegs, 128'h0);
      CoreWriteAssert = 1'b0;
      @(negedge CoreClock);
      Reset = 1'b0;
      access(1'b1, 1'b0, 32'h40, 32'h0);
      chk32("abort_readback", rdat, 32'h11111111);
      idle_check("abort_rb");

      // Reset while waiting on RAM: no OK, next read completes normally
      CoreAddress = 32'h10; CoreReadAssert = 1'b1;
      @(negedge CoreClock);
      @(negedge CoreClock);
      Reset = 1'b1; CoreReadAssert = 1'b0;
      #1;
      chk1("rstwait_rok", CoreReadOK, 1'b0);
      chk32("rstwait_rdata", CoreReadData, 32'h0);
      okcnt = 0;
      repeat (3) begin
         @(negedge CoreClock);
         if (CoreReadOK || CoreWriteOK) okcnt++;
      end
      chk32("rstwait_no_ok", okcnt, 0);
      Reset = 1'b0;
      access(1'b1, 1'b0, 32'h10, 32'h0);
      chk32("rstwait_lat", lat, LAT + 1);
      chk32("rstwait_data", rdat, 32'hDEADBEEF);
      idle_check("rstwait");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
